// File: rtl/decoder_sched_pkg.sv
// Shared types and constants for the decoder core scheduler.
package decoder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } sched_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_VEC_LEN    = 64;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decoder_core_arbiter_rr.sv
// Round-robin priority pick: first set request at or above ptr, wrapping modulo N.
module rr_arbiter
  import decoder_sched_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    logic        found;
    int unsigned k;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!found && req[k]) begin
        found      = 1'b1;
        gnt_oh[k]  = 1'b1;
        gnt_idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/decoder_core_arbiter.sv
// Shares one decoder core among NUM_REQ requesters, one whole packet per grant.
// Optional stall watchdog compiled in with DECSCHED_WATCHDOG_EN.
module decoder_core_arbiter
  import decoder_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned VEC_LEN     = DEF_VEC_LEN,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic                          rsp_last,
  output logic                          core_cfg_start,
  output logic                          core_in_valid,
  input  logic                          core_in_ready,
  output logic [DATA_WIDTH-1:0]         core_x_data,
  input  logic                          core_out_valid,
  output logic                          core_out_ready,
  input  logic [DATA_WIDTH-1:0]         core_y_data,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(VEC_LEN);

  sched_state_e state, state_nx;

  logic [IW-1:0]      rr_ptr, grant, arb_idx, grant_inc;
  logic [NUM_REQ-1:0] unused_arb_oh;
  logic [CW-1:0]      in_cnt, out_cnt;
  logic               in_act, out_act, in_hs, out_hs, run_done, abort;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_oh  (unused_arb_oh),
    .gnt_idx (arb_idx)
  );

  assign grant_inc = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign in_act    = (state == RUN) && (in_cnt < FULL);
  assign out_act   = (state == RUN) && (out_cnt < FULL);
  assign in_hs     = in_act && req_valid[grant] && core_in_ready;
  assign out_hs    = out_act && core_out_valid && rsp_ready;
  assign run_done  = (state == RUN) && (in_cnt == FULL) && (out_cnt == FULL);
  assign rsp_id    = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    req_ready      = '0;
    core_in_valid  = 1'b0;
    core_x_data    = '0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    rsp_last       = 1'b0;
    core_out_ready = 1'b0;
    core_cfg_start = (state == START);
    busy           = (state != IDLE);
    if (in_act) begin
      core_in_valid    = req_valid[grant];
      req_ready[grant] = core_in_ready;
      core_x_data      = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
    end
    if (out_act) begin
      rsp_valid      = core_out_valid;
      core_out_ready = rsp_ready;
      rsp_data       = core_y_data;
      rsp_last       = core_out_valid && (out_cnt == FULL - 1'b1);
    end
    case (state)
      IDLE:    if (|req_valid) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (run_done || abort) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      grant   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        IDLE:  if (|req_valid) grant <= arb_idx;
        START: begin
          in_cnt  <= '0;
          out_cnt <= '0;
        end
        RUN: begin
          if (run_done || abort) begin
            rr_ptr <= grant_inc;
            if (abort) begin
              in_cnt  <= '0;
              out_cnt <= '0;
            end
          end else begin
            if (in_hs)  in_cnt  <= in_cnt + 1'b1;
            if (out_hs) out_cnt <= out_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DECSCHED_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog;
  logic          err_q;

  // Abort on the edge that would make the idle count reach WDOG_CYCLES; the pulse follows in IDLE.
  assign abort = (state == RUN) && !in_hs && !out_hs && (wdog == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if ((state != RUN) || in_hs || out_hs || abort) wdog <= '0;
      else                                           wdog <= wdog + 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign abort           = 1'b0;
  assign err_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_core_arbiter.sv
// Scoreboard bench for decoder_core_arbiter with an echoing core model (NUM_REQ=4, VEC_LEN=4).
module tb_decoder_core_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_data;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        core_cfg_start, core_in_valid, core_in_ready;
  logic [15:0] core_x_data, core_y_data;
  logic        core_out_valid, core_out_ready, busy, err_timeout;

  decoder_core_arbiter #(
    .DATA_WIDTH(16), .NUM_REQ(4), .VEC_LEN(4), .WDOG_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_last(rsp_last),
    .core_cfg_start(core_cfg_start), .core_in_valid(core_in_valid),
    .core_in_ready(core_in_ready), .core_x_data(core_x_data),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .core_y_data(core_y_data), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic [15:0] src_mem [4][16];
  int          src_wr [4];
  int          src_rd [4];
  int          bcnt [4];
  int          in_beats [4];
  logic [3:0]  en;
  logic [15:0] cmem [16];
  int          cw, cr;
  logic        core_out_en;
  logic [3:0]  rdy_pat;
  int          cyc;
  exp_t        sb [$];
  int          gnt_log [$];
  logic        need_log;
  int          rsp_total, start_cnt, err_cnt, err_cyc, last_hs_cyc;
  logic        err_busy, iso_on, iso_bad_rdy, iso_bad_data;
  int          exp_order [5] = '{0, 1, 3, 0, 1};
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]         = en[i] && (src_rd[i] != src_wr[i]);
      req_data[i*16 +: 16] = src_mem[i][src_rd[i] % 16];
    end
    core_out_valid = core_out_en && (cw != cr);
    core_y_data    = cmem[cr % 16];
    rsp_ready      = rdy_pat[cyc % 4];
  endtask

  task automatic load(input int id, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      src_mem[id][src_wr[id] % 16] = base + 16'(k);
      src_wr[id]++;
    end
    drive();
  endtask

  task automatic flush();
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      src_rd[i] = src_wr[i];
      bcnt[i]   = 0;
    end
    cw = 0;
    cr = 0;
    need_log = 1'b0;
    drive();
  endtask

  // Sample at negedge, apply handshake effects just after the following posedge.
  task automatic tick();
    logic [3:0]  ih;
    logic        c_in, c_out, st;
    logic [15:0] xd;
    exp_t        e;
    @(negedge clk);
    ih    = req_valid & req_ready;
    c_in  = core_in_valid & core_in_ready;
    c_out = core_out_valid & core_out_ready;
    st    = core_cfg_start;
    xd    = core_x_data;
    if (st) begin start_cnt++; need_log = 1'b1; end
    if (err_timeout) begin
      if (err_cnt == 0) begin err_cyc = cyc; err_busy = busy; end
      err_cnt++;
    end
    if (c_in || c_out) last_hs_cyc = cyc;
    if (iso_on) begin
      if (req_ready[1]) iso_bad_rdy = 1'b1;
      if (core_in_valid && core_x_data == 16'hBEEF) iso_bad_data = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (ih[i]) begin
        if (need_log) begin gnt_log.push_back(i); need_log = 1'b0; end
        e.id   = 2'(i);
        e.data = src_mem[i][src_rd[i] % 16];
        e.last = (bcnt[i] == 3);
        sb.push_back(e);
        bcnt[i] = (bcnt[i] + 1) % 4;
        in_beats[i]++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      rsp_total++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_last", 32'(rsp_last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (ih[i]) src_rd[i]++;
    if (st) begin cw = 0; cr = 0; end
    if (c_in) begin cmem[cw % 16] = xd; cw++; end
    if (c_out) cr++;
    drive();
  endtask

  task automatic wait_rsp(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && rsp_total < target; k++) tick();
    chk(tag, 32'(rsp_total), 32'(target));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      src_wr[i] = 0; src_rd[i] = 0; bcnt[i] = 0; in_beats[i] = 0;
    end
    en = 4'hF; cw = 0; cr = 0; core_out_en = 1'b1; rdy_pat = 4'hF; cyc = 0;
    core_in_ready = 1'b1; need_log = 1'b0; rsp_total = 0; start_cnt = 0;
    err_cnt = 0; err_cyc = 0; last_hs_cyc = 0; err_busy = 1'b0;
    iso_on = 1'b0; iso_bad_rdy = 1'b0; iso_bad_data = 1'b0;
    drive();
    tick();
    tick();
    chk("rst_outs", 32'({req_ready, rsp_valid, rsp_last, core_cfg_start, core_in_valid,
                         core_out_ready, busy, err_timeout}), 32'd0);
    rst_n = 1'b1;
    tick();

    // single requester
    load(2, 16'h0011, 4);
    wait_rsp(4, 60, "t1_rsp_cnt");
    tick();
    tick();
    chk("t1_starts", 32'(start_cnt), 32'd1);
    chk("t1_gnt_n", 32'(gnt_log.size()), 32'd1);
    if (gnt_log.size() == 1) chk("t1_gnt", 32'(gnt_log[0]), 32'd2);
    chk("t1_busy", 32'(busy), 32'd0);

    // round robin among 0, 1, 3 from a fresh pointer
    do_reset();
    gnt_log.delete();
    rsp_total = 0;
    load(0, 16'h0100, 8);
    load(1, 16'h0200, 8);
    load(3, 16'h0400, 4);
    wait_rsp(20, 300, "t2_rsp_cnt");
    tick();
    tick();
    chk("t2_gnt_n", 32'(gnt_log.size()), 32'd5);
    if (gnt_log.size() == 5)
      for (int k = 0; k < 5; k++) chk("t2_gnt_order", 32'(gnt_log[k]), 32'(exp_order[k]));

    // backpressure on both sides
    rsp_total = 0;
    begin
      int snap;
      snap = in_beats[0];
      rdy_pat = 4'b1001;
      core_in_ready = 1'b0;
      load(0, 16'h0300, 4);
      repeat (5) tick();
      core_in_ready = 1'b1;
      wait_rsp(4, 100, "t3_rsp_cnt");
      chk("t3_busy_hold", 32'(busy), 32'd1);
      tick();
      chk("t3_busy_exit", 32'(busy), 32'd0);
      chk("t3_in_beats", 32'(in_beats[0] - snap), 32'd4);
      rdy_pat = 4'hF;
      drive();
    end

    // non-granted requester isolation
    rsp_total = 0;
    start_cnt = 0;
    load(0, 16'h0500, 4);
    for (int k = 0; k < 20 && start_cnt == 0; k++) tick();
    chk("t4_started", 32'(start_cnt), 32'd1);
    load(1, 16'hBEEF, 4);
    iso_on = 1'b1;
    wait_rsp(4, 60, "t4_rsp_cnt");
    iso_on = 1'b0;
    en[1] = 1'b0;
    src_rd[1] = src_wr[1];
    drive();
    chk("t4_iso_ready", 32'(iso_bad_rdy), 32'd0);
    chk("t4_iso_data", 32'(iso_bad_data), 32'd0);
    tick();
    tick();
    en[1] = 1'b1;
    drive();

    // reset mid-packet
    begin
      int snap;
      snap = in_beats[3];
      load(3, 16'h0600, 4);
      for (int k = 0; k < 30 && (in_beats[3] - snap) < 2; k++) tick();
      chk("t5_two_beats", 32'(in_beats[3] - snap), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("t5_outs_zero", 32'({req_ready, rsp_valid, rsp_last, core_cfg_start, core_in_valid,
                               core_out_ready, busy, err_timeout}), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      flush();
      tick();
      rst_n = 1'b1;
      gnt_log.delete();
      rsp_total = 0;
      load(0, 16'h0700, 4);
      load(1, 16'h0800, 4);
      wait_rsp(8, 120, "t5_rsp_cnt");
      chk("t5_gnt_n", 32'(gnt_log.size()), 32'd2);
      if (gnt_log.size() == 2) begin
        chk("t5_gnt_first", 32'(gnt_log[0]), 32'd0);
        chk("t5_gnt_second", 32'(gnt_log[1]), 32'd1);
      end
      tick();
      tick();
    end

`ifdef DECSCHED_WATCHDOG_EN
    // watchdog abort with the core never producing output
    core_out_en = 1'b0;
    err_cnt = 0;
    load(2, 16'h0900, 4);
    for (int k = 0; k < 60 && err_cnt == 0; k++) tick();
    tick();
    tick();
    chk("t6_err_pulses", 32'(err_cnt), 32'd1);
    chk("t6_err_delay", 32'(err_cyc - last_hs_cyc), 32'd9);
    chk("t6_err_busy", 32'(err_busy), 32'd0);
    core_out_en = 1'b1;
    flush();
    gnt_log.delete();
    rsp_total = 0;
    load(2, 16'h0A00, 4);
    load(3, 16'h0B00, 4);
    wait_rsp(8, 120, "t6_rsp_cnt");
    chk("t6_gnt_n", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) chk("t6_gnt_next", 32'(gnt_log[0]), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
